// File: rtl/pc_pkg.sv
// pc_pkg: shared operation encoding and default parameter values for the PC sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_pkg;

  // One decoded operation per cycle feeds the single PC register.
  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_JUMP,
    PC_BRANCH,
    PC_CALL,
    PC_RET
  } pc_op_e;

  localparam int unsigned PC_ADDR_BITS_DEF   = 5;
  localparam int unsigned PC_STACK_DEPTH_DEF = 4;
  localparam int unsigned PC_RESET_ADDR_DEF  = 0;

  // Level counter must be able to hold the value DEPTH itself (full).
  function automatic int unsigned pc_level_bits(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// return_stack: LIFO of return addresses with an occupancy counter.
// Latency: push/pop take effect at the next posedge; top is combinational from storage.
// Backpressure: push while full and pop while empty are ignored; the caller flags them.
// Ports: clk, rst (sync, active-high); push, pop, push_value in;
//        full, empty, top (entry last pushed), level (entries stored) out.
module return_stack
  import pc_pkg::*;
#(
  parameter int unsigned DEPTH = PC_STACK_DEPTH_DEF,
  parameter int unsigned WIDTH = PC_ADDR_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_value,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = pc_level_bits(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LVL_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // DEPTH is a power of two, so the low bits of the level are the next free
  // slot and one below that (modulo DEPTH) is the top entry. The wrapped
  // values at full/empty are never used because push/pop are blocked there.
  assign wr_ptr = level_q[PTR_W-1:0];
  assign rd_ptr = wr_ptr - PTR_W'(1);

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign top   = mem_q[rd_ptr];
  assign level = level_q;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    level_d = level_q;
    if (do_push) begin
      level_d = level_q + LVL_W'(1);
    end else if (do_pop) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  // Storage is not reset: entries above the level are unreachable.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wr_ptr] <= push_value;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with increment, absolute jump, relative branch, call/return.
// Latency: one cycle from request to instruction_address (registered PC).
// Backpressure: stall freezes PC, stack and flags; lower-priority requests are dropped.
// Ports: clk, rst (sync, active-high), stall, jump_enable/jump_value, branch_enable/
//        branch_offset, call_enable, ret_enable in; instruction_address, stack_level,
//        stack_overflow, stack_underflow (sticky until reset) out.
// Build option PC_STACK_EN: includes the return stack. Without it call_enable behaves as
// jump_enable, ret_enable is ignored, and stack_level/flags read constant 0.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = PC_ADDR_BITS_DEF,
  parameter int unsigned STACK_DEPTH = PC_STACK_DEPTH_DEF,
  parameter int unsigned RESET_ADDR  = PC_RESET_ADDR_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         jump_enable,
  input  logic [ADDR_BITS-1:0]         jump_value,
  input  logic                         branch_enable,
  input  logic [ADDR_BITS-1:0]         branch_offset,
  input  logic                         call_enable,
  input  logic                         ret_enable,
  output logic [ADDR_BITS-1:0]         instruction_address,
  output logic [$clog2(STACK_DEPTH):0] stack_level,
  output logic                         stack_overflow,
  output logic                         stack_underflow
);

  pc_op_e               op;
  logic [ADDR_BITS-1:0] pc_q, pc_d, pc_inc;

  // Priority decode; reset is applied directly in the registers below.
  always_comb begin : decode
    op = PC_INC;
    if (stall) begin
      op = PC_HOLD;
    end
`ifdef PC_STACK_EN
    else if (ret_enable) begin
      op = PC_RET;
    end else if (call_enable) begin
      op = PC_CALL;
    end
`else
    else if (call_enable) begin
      op = PC_JUMP;
    end
`endif
    else if (jump_enable) begin
      op = PC_JUMP;
    end else if (branch_enable) begin
      op = PC_BRANCH;
    end
  end

`ifdef PC_STACK_EN
  logic                 stk_push, stk_pop, stk_full, stk_empty;
  logic [ADDR_BITS-1:0] stk_top;
  logic                 ovf_q, ovf_d, unf_q, unf_d;

  // The return address pushed on a call is the incremented PC.
  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_BITS)
  ) u_return_stack (
    .clk        (clk),
    .rst        (rst),
    .push       (stk_push),
    .pop        (stk_pop),
    .push_value (pc_inc),
    .full       (stk_full),
    .empty      (stk_empty),
    .top        (stk_top),
    .level      (stack_level)
  );

  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;
`else
  logic unused_ret;
  assign unused_ret      = ret_enable;
  assign stack_level     = '0;
  assign stack_overflow  = 1'b0;
  assign stack_underflow = 1'b0;
`endif

  always_comb begin : next_state
    pc_inc = pc_q + ADDR_BITS'(1);
    pc_d   = pc_q;
`ifdef PC_STACK_EN
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
`endif
    case (op)
      PC_HOLD:   pc_d = pc_q;
      PC_INC:    pc_d = pc_inc;
      PC_JUMP:   pc_d = jump_value;
      // Same-width modular add equals adding the sign-extended offset.
      PC_BRANCH: pc_d = pc_q + branch_offset;
`ifdef PC_STACK_EN
      PC_CALL: begin
        if (stk_full) begin
          ovf_d = 1'b1;
          pc_d  = pc_inc;
        end else begin
          stk_push = 1'b1;
          pc_d     = jump_value;
        end
      end
      PC_RET: begin
        if (stk_empty) begin
          unf_d = 1'b1;
          pc_d  = pc_inc;
        end else begin
          stk_pop = 1'b1;
          pc_d    = stk_top;
        end
      end
`endif
      default:   pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= ADDR_BITS'(RESET_ADDR);
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef PC_STACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
`endif

  assign instruction_address = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int MOD   = 1 << AW;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef PC_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, stall, jump_enable, branch_enable, call_enable, ret_enable;
  logic [AW-1:0] jump_value, branch_offset;
  logic [AW-1:0] instruction_address;
  logic [LW-1:0] stack_level;
  logic          stack_overflow, stack_underflow;

  pc_sequencer #(
    .ADDR_BITS   (AW),
    .STACK_DEPTH (DEPTH),
    .RESET_ADDR  (0)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .jump_enable         (jump_enable),
    .jump_value          (jump_value),
    .branch_enable       (branch_enable),
    .branch_offset       (branch_offset),
    .call_enable         (call_enable),
    .ret_enable          (ret_enable),
    .instruction_address (instruction_address),
    .stack_level         (stack_level),
    .stack_overflow      (stack_overflow),
    .stack_underflow     (stack_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit stall;
    bit jump;
    int jv;
    bit branch;
    int bo;
    bit call;
    bit ret;
  } in_t;

  typedef struct {
    in_t in;
    int  pc;
    int  lvl;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: PC as an integer, return stack as a queue.
  int m_pc = 0;
  int m_stk[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  function automatic in_t mk(input bit r, input bit s, input bit j, input int jv,
                             input bit b, input int bo, input bit c, input bit rt);
    in_t x;
    x.rst = r; x.stall = s; x.jump = j; x.jv = jv;
    x.branch = b; x.bo = bo; x.call = c; x.ret = rt;
    return x;
  endfunction

  function automatic vec_t mkv(input in_t x, input int pc, input int lvl);
    vec_t v;
    v.in = x; v.pc = pc; v.lvl = lvl;
    return v;
  endfunction

  function automatic in_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_step(input in_t x);
    int off;
    if (x.rst) begin
      m_pc = 0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (x.stall) begin
      m_pc = m_pc;
    end else if (STK && x.ret) begin
      if (m_stk.size() > 0) begin
        m_pc = m_stk.pop_back();
      end else begin
        m_unf = 1'b1;
        m_pc  = (m_pc + 1) % MOD;
      end
    end else if (x.call) begin
      if (!STK) begin
        m_pc = x.jv;
      end else if (m_stk.size() < DEPTH) begin
        m_stk.push_back((m_pc + 1) % MOD);
        m_pc = x.jv;
      end else begin
        m_ovf = 1'b1;
        m_pc  = (m_pc + 1) % MOD;
      end
    end else if (x.jump) begin
      m_pc = x.jv;
    end else if (x.branch) begin
      off  = (x.bo >= MOD / 2) ? x.bo - MOD : x.bo;
      m_pc = (m_pc + off + MOD) % MOD;
    end else begin
      m_pc = (m_pc + 1) % MOD;
    end
  endfunction

  task automatic cycle(input in_t x);
    @(negedge clk);
    rst           = x.rst;
    stall         = x.stall;
    jump_enable   = x.jump;
    jump_value    = AW'(x.jv);
    branch_enable = x.branch;
    branch_offset = AW'(x.bo);
    call_enable   = x.call;
    ret_enable    = x.ret;
    @(posedge clk);
    #1;
    model_step(x);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},  int'(instruction_address), m_pc);
    chk({tag, ".lvl"}, int'(stack_level),         m_stk.size());
    chk({tag, ".ovf"}, int'(stack_overflow),      int'(m_ovf));
    chk({tag, ".unf"}, int'(stack_underflow),     int'(m_unf));
  endtask

  initial begin
    vec_t tbl[18];
    in_t  x;

    rst = 1'b1; stall = 1'b0; jump_enable = 1'b0; jump_value = '0;
    branch_enable = 1'b0; branch_offset = '0; call_enable = 1'b0; ret_enable = 1'b0;

    // Priority, branch arithmetic and wrap vectors (no stack traffic).
    tbl[0]  = mkv(mk(1, 0, 0, 0,  0, 0,  0, 0), 0,  0);
    tbl[1]  = mkv(idle(), 1, 0);
    tbl[2]  = mkv(idle(), 2, 0);
    tbl[3]  = mkv(idle(), 3, 0);
    tbl[4]  = mkv(idle(), 4, 0);
    tbl[5]  = mkv(mk(0, 1, 1, 20, 1, 3,  0, 0), 4,  0);
    tbl[6]  = mkv(mk(0, 0, 1, 20, 1, 3,  0, 0), 20, 0);
    tbl[7]  = mkv(mk(0, 0, 0, 0,  1, 3,  0, 0), 23, 0);
    tbl[8]  = mkv(mk(0, 0, 1, 2,  0, 0,  0, 0), 2,  0);
    tbl[9]  = mkv(mk(0, 0, 0, 0,  1, 29, 0, 0), 31, 0);
    tbl[10] = mkv(idle(), 0, 0);
    tbl[11] = mkv(mk(0, 0, 0, 0,  1, 31, 0, 0), 31, 0);
    tbl[12] = mkv(mk(1, 1, 1, 7,  1, 3,  0, 0), 0,  0);
    tbl[13] = mkv(mk(0, 1, 0, 0,  0, 0,  0, 0), 0,  0);
    tbl[14] = mkv(mk(0, 0, 1, 31, 0, 0,  0, 0), 31, 0);
    tbl[15] = mkv(mk(0, 0, 0, 0,  1, 1,  0, 0), 0,  0);
    tbl[16] = mkv(mk(0, 0, 0, 0,  1, 15, 0, 0), 15, 0);
    tbl[17] = mkv(mk(0, 0, 0, 0,  1, 16, 0, 0), 31, 0);

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].in);
      chk($sformatf("vec%0d.pc", i),  int'(instruction_address), tbl[i].pc);
      chk($sformatf("vec%0d.lvl", i), int'(stack_level),         tbl[i].lvl);
    end

    // Reset then 35 free-running cycles: 0..31, 0, 1, 2.
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0));
    chk("wrap0.pc", int'(instruction_address), 0);
    for (int i = 1; i < 35; i++) begin
      cycle(idle());
      chk($sformatf("wrap%0d.pc", i), int'(instruction_address), i % MOD);
    end

    // Call at 3 to 10, return at 12.
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) cycle(idle());
    chk("call.start_pc", int'(instruction_address), 3);
    cycle(mk(0, 0, 0, 10, 0, 0, 1, 0));
    chk("call.pc",  int'(instruction_address), 10);
    chk("call.lvl", int'(stack_level),         STK ? 1 : 0);
    cycle(idle());
    cycle(idle());
    chk("call.body_pc", int'(instruction_address), 12);
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 1));
    chk("ret.pc",  int'(instruction_address), STK ? 4 : 13);
    chk("ret.lvl", int'(stack_level),         0);
    chk("ret.ovf", int'(stack_overflow),      0);
    chk("ret.unf", int'(stack_underflow),     0);

    // Five calls then five returns against a depth-4 stack.
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      cycle(mk(0, 0, 0, 10, 0, 0, 1, 0));
      chk_model($sformatf("fill%0d", i));
    end
    chk("fill.lvl", int'(stack_level), STK ? 4 : 0);
    cycle(mk(0, 0, 0, 10, 0, 0, 1, 0));
    chk("ovf.pc",  int'(instruction_address), STK ? 11 : 10);
    chk("ovf.lvl", int'(stack_level),         STK ? 4 : 0);
    chk("ovf.flag", int'(stack_overflow),     STK ? 1 : 0);
    for (int i = 0; i < 4; i++) begin
      cycle(mk(0, 0, 0, 0, 0, 0, 0, 1));
      chk_model($sformatf("drain%0d", i));
    end
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 1));
    chk("unf.pc",   int'(instruction_address), STK ? 2 : 15);
    chk("unf.lvl",  int'(stack_level),         0);
    chk("unf.flag", int'(stack_underflow),     STK ? 1 : 0);
    chk("unf.ovf_sticky", int'(stack_overflow), STK ? 1 : 0);
    cycle(mk(0, 1, 0, 0, 0, 0, 1, 1));
    chk_model("stall_flags");
    cycle(mk(1, 1, 0, 0, 0, 0, 0, 0));
    chk("clr.pc",  int'(instruction_address), 0);
    chk("clr.ovf", int'(stack_overflow),      0);
    chk("clr.unf", int'(stack_underflow),     0);
    chk("clr.lvl", int'(stack_level),         0);

    // Randomized traffic against the reference model.
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 800; i++) begin
      x.rst    = ($urandom_range(0, 99) == 0);
      x.stall  = ($urandom_range(0, 7) == 0);
      x.ret    = ($urandom_range(0, 4) == 0);
      x.call   = ($urandom_range(0, 3) == 0);
      x.jump   = ($urandom_range(0, 5) == 0);
      x.branch = ($urandom_range(0, 3) == 0);
      x.jv     = int'($urandom_range(0, MOD - 1));
      x.bo     = int'($urandom_range(0, MOD - 1));
      cycle(x);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
